gx4000_cpr_loader: RTL and testbench
====================================

// Module: gx4000_cpr_loader
// PURPOSE
//  Writer side of the GX4000 cartridge ROM store: parses a .CPR (RIFF "AMS!") image from the ioctl download stream.
//  Each "cbNN" chunk goes to SDRAM at ROM_BASE + {NN[4:0], offset[13:0]}, the 16 KB bank layout the cartridge read path banks into.
//  Sits between the HPS ioctl port and the SDRAM write arbiter; backpressures the host with ioctl_wait.
// PARAMETERS
//  ROM_BASE   23'h000000  SDRAM byte address of bank 0
//  BANK_BYTES 16384       bytes per bank; chunk bytes at or beyond this are consumed, not written
// PORTS
//  clk_sys         in   1   system clock
//  reset           in   1   synchronous, active-high reset
//  ioctl_download  in   1   high for the whole image transfer
//  ioctl_wr        in   1   one-cycle strobe: ioctl_dout valid
//  ioctl_dout      in   8   image byte, sequential stream order
//  ioctl_wait      out  1   high: host must not strobe ioctl_wr
//  mem_addr        out  23  SDRAM write address
//  mem_data        out  8   SDRAM write data
//  mem_wr          out  1   write request, held until mem_ack
//  mem_ack         in   1   one-cycle write completion
//  load_done       out  1   level: image parsed cleanly
//  load_error      out  1   level: bad magic or truncated image
//  bank_mask       out  32  bit N set once any byte of bank N is written
// BEHAVIOUR
//  Reset: state IDLE; ioctl_wait=0, mem_wr=0, mem_addr=0, mem_data=0, load_done=0, load_error=0, bank_mask=0.
//  Rising edge of ioctl_download (registered compare): clear done/error/bank_mask; byte counter=0; state RIFF_ID.
//  States and transitions, one byte per ioctl_wr:
//   RIFF_ID (4 bytes): must be "RIFF", else ERROR. RIFF_SIZE (4 bytes): ignored. FORM_ID (4 bytes): must be "AMS!", else ERROR.
//   CHUNK_ID (4 bytes): "cb" + two ASCII decimal digits, value 00..31 -> bank=NN; any other ID (incl. cb32..cb99) -> skip chunk.
//   CHUNK_SIZE (4 bytes): 32-bit little-endian; size 0 -> PAD check; otherwise CHUNK_DATA for a cb chunk, SKIP for any other.
//   CHUNK_DATA: offset 0..size-1; offset<BANK_BYTES -> issue write; else discard. SKIP: discard size bytes.
//   PAD: odd size -> discard exactly one pad byte, then CHUNK_ID. Even size -> CHUNK_ID directly.
//  Write handshake:
//   Cycle after accepted ioctl_wr: mem_wr=1 with addr and data stable; ioctl_wait=1 in the same cycle.
//   Both held until mem_ack; they drop the cycle after mem_ack. At most one write outstanding.
//   mem_ack while mem_wr=0 is ignored.
//  Header and skipped bytes never raise ioctl_wait; they are accepted at full strobe rate.
//  Address arithmetic: ROM_BASE + bank*BANK_BYTES + offset, 23 bits, wraps modulo 2^23.
//  bank_mask[bank] is set on that bank's first write request.
//  Falling edge of ioctl_download:
//   In CHUNK_ID with 0 ID bytes consumed -> load_done=1.
//   In any other non-ERROR state -> load_error=1 (truncated); a pending write still completes, then IDLE.
//  ERROR: ignore bytes, no writes, ioctl_wait=0; load_error=1 until next download start or reset.
//  ioctl_wr in IDLE, DONE or ERROR is ignored.
//  A duplicate cbNN chunk overwrites the earlier data; the last chunk wins.
//  Reset mid-operation: immediate return to reset values; an in-flight mem_wr is abandoned (arbiter must tolerate this).
// CONFIGURATION
//  CPR_FILL_EN defined:
//   A cb chunk whose size is below BANK_BYTES is followed by a FILL state.
//   FILL writes 8'hFF to offsets size..BANK_BYTES-1 through the same handshake, holding ioctl_wait=1 throughout.
//   The pad-byte check follows FILL.
//  CPR_FILL_EN undefined: no FILL state; unwritten bank bytes keep their prior SDRAM contents.
// TESTING
//  "RIFF",size,"AMS!","cb00",04 00 00 00,11 22 33 44 -> writes 0x000000..0x000003 = 11,22,33,44; drop download -> load_done=1, bank_mask=0x1.
//  Chunk "cb05", size 2, data AA BB -> writes at 0x014000=AA and 0x014001=BB; bank_mask bit 5 set.
//  Chunk "fmt ", size 3, data, pad byte, then "cb01" size 1 -> no writes for fmt; one write at 0x004000; pad byte not written.
//  First 4 bytes "RIFX" -> load_error=1, zero mem_wr pulses for the rest of the stream.
//  mem_ack delayed 5 cycles -> mem_wr and ioctl_wait high 6 cycles, addr/data stable; next byte accepted only after wait drops.
//  Download drops after 2 of 4 data bytes -> load_error=1, load_done=0.
//  Reset asserted mid-CHUNK_DATA -> next cycle all outputs at reset values.
//  CPR_FILL_EN build, cb02 size 1 -> 16384 writes (first = data, rest = FF) at 0x008000..0x00BFFF.

Source files
------------

// File: rtl/gx4000_cpr_loader.sv
`default_nettype none
// ============================================================================
// Module      : gx4000_cpr_loader
// Description : Parses a .CPR (RIFF "AMS!") cartridge image from the ioctl
//               stream and writes each cbNN chunk into its 16 KB SDRAM bank.
//               Optional build macro CPR_FILL_EN pads short banks with 8'hFF.
// Revision    : 1.0  initial release
// ============================================================================
module gx4000_cpr_loader #(
    parameter logic [22:0] ROM_BASE   = 23'h000000,
    parameter int          BANK_BYTES = 16384
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [22:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_wr,
    input  logic        mem_ack,
    output logic        load_done,
    output logic        load_error,
    output logic [31:0] bank_mask
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_RIFF_ID, ST_RIFF_SIZE, ST_FORM_ID, ST_CHUNK_ID, ST_CHUNK_SIZE,
        ST_CHUNK_DATA, ST_SKIP, ST_PAD, ST_FILL, ST_DONE, ST_ERROR
    } state_t;

    localparam logic [31:0] BANK_LIM  = 32'(BANK_BYTES);
    localparam logic [22:0] BANK_SZ23 = 23'(BANK_BYTES);

    state_t      state, state_nx;
    logic        dl_q;
    logic [1:0]  cnt;
    logic [23:0] id_sr;
    logic [31:0] size_r;
    logic [31:0] off;
    logic        is_cb;
    logic [4:0]  bank;

    logic        accept, dl_rise, dl_fall;
    logic [31:0] word, size_full;
    logic [7:0]  dig_hi, dig_lo, cb_val;
    logic        cb_ok, data_last;
    state_t      pad_next, after_data;
    logic        hdr_byte, latch_id, off_clr, off_inc, write_go, fill_wr, set_done, set_err;

    assign ioctl_wait = mem_wr || (state == ST_FILL);
    assign accept     = ioctl_wr && !ioctl_wait;
    assign dl_rise    = ioctl_download && !dl_q;
    assign dl_fall    = !ioctl_download && dl_q;
    assign word       = {id_sr, ioctl_dout};
    assign size_full  = {ioctl_dout, size_r[31:8]};
    assign data_last  = (off == size_r - 32'd1);

    // Chunk ID "cbNN": id_sr holds 'c','b',N1 when the final digit arrives
    assign dig_hi = id_sr[7:0] - 8'd48;
    assign dig_lo = ioctl_dout - 8'd48;
    assign cb_val = dig_hi * 8'd10 + dig_lo;
    assign cb_ok  = (id_sr[23:8] == 16'h6362) && (dig_hi < 8'd10) && (dig_lo < 8'd10)
                    && (cb_val < 8'd32);

    assign pad_next = size_r[0] ? ST_PAD : ST_CHUNK_ID;
`ifdef CPR_FILL_EN
    assign after_data = (size_r < BANK_LIM) ? ST_FILL : pad_next;
`else
    assign after_data = pad_next;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        hdr_byte = 1'b0;
        latch_id = 1'b0;
        off_clr  = 1'b0;
        off_inc  = 1'b0;
        write_go = 1'b0;
        fill_wr  = 1'b0;
        set_done = 1'b0;
        set_err  = 1'b0;
        if (dl_rise) begin
            state_nx = ST_RIFF_ID;
        end else if (dl_fall) begin
            if (state == ST_CHUNK_ID && cnt == 2'd0) begin
                state_nx = ST_DONE;
                set_done = 1'b1;
            end else if (state != ST_IDLE && state != ST_DONE && state != ST_ERROR) begin
                state_nx = ST_IDLE;
                set_err  = 1'b1;
            end
        end else begin
            case (state)
                ST_RIFF_ID, ST_RIFF_SIZE, ST_FORM_ID, ST_CHUNK_ID, ST_CHUNK_SIZE: begin
                    if (accept) begin
                        hdr_byte = 1'b1;
                        if (cnt == 2'd3) begin
                            case (state)
                                ST_RIFF_ID: begin
                                    state_nx = (word == "RIFF") ? ST_RIFF_SIZE : ST_ERROR;
                                    set_err  = (word != "RIFF");
                                end
                                ST_RIFF_SIZE: state_nx = ST_FORM_ID;
                                ST_FORM_ID: begin
                                    state_nx = (word == "AMS!") ? ST_CHUNK_ID : ST_ERROR;
                                    set_err  = (word != "AMS!");
                                end
                                ST_CHUNK_ID: begin
                                    state_nx = ST_CHUNK_SIZE;
                                    latch_id = 1'b1;
                                end
                                default: begin
                                    off_clr = 1'b1;
                                    if (size_full == 32'd0) state_nx = ST_CHUNK_ID;
                                    else if (is_cb)         state_nx = ST_CHUNK_DATA;
                                    else                    state_nx = ST_SKIP;
                                end
                            endcase
                        end
                    end
                end
                ST_CHUNK_DATA: begin
                    if (accept) begin
                        off_inc  = 1'b1;
                        write_go = (off < BANK_LIM);
                        if (data_last) state_nx = after_data;
                    end
                end
                ST_SKIP: begin
                    if (accept) begin
                        off_inc = 1'b1;
                        if (data_last) state_nx = pad_next;
                    end
                end
                ST_PAD: begin
                    if (accept) state_nx = ST_CHUNK_ID;
                end
`ifdef CPR_FILL_EN
                ST_FILL: begin
                    if (!mem_wr) begin
                        write_go = 1'b1;
                        fill_wr  = 1'b1;
                        off_inc  = 1'b1;
                        if (off == BANK_LIM - 32'd1) state_nx = pad_next;
                    end
                end
`endif
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_q       <= 1'b0;
            cnt        <= 2'd0;
            id_sr      <= 24'd0;
            size_r     <= 32'd0;
            off        <= 32'd0;
            is_cb      <= 1'b0;
            bank       <= 5'd0;
            mem_wr     <= 1'b0;
            mem_addr   <= 23'd0;
            mem_data   <= 8'd0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            bank_mask  <= 32'd0;
        end else begin
            dl_q <= ioctl_download;
            if (mem_wr && mem_ack) mem_wr <= 1'b0;
            if (dl_rise) begin
                load_done  <= 1'b0;
                load_error <= 1'b0;
                bank_mask  <= 32'd0;
                cnt        <= 2'd0;
            end
            if (hdr_byte) begin
                cnt   <= cnt + 2'd1;
                id_sr <= {id_sr[15:0], ioctl_dout};
                if (state == ST_CHUNK_SIZE) size_r <= size_full;
            end
            if (latch_id) begin
                is_cb <= cb_ok;
                bank  <= cb_val[4:0];
            end
            if (off_clr) off <= 32'd0;
            if (off_inc) off <= off + 32'd1;
            if (write_go) begin
                mem_wr          <= 1'b1;
                mem_addr        <= ROM_BASE + {18'd0, bank} * BANK_SZ23 + off[22:0];
                mem_data        <= fill_wr ? 8'hFF : ioctl_dout;
                bank_mask[bank] <= 1'b1;
            end
            if (set_done) load_done  <= 1'b1;
            if (set_err)  load_error <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gx4000_cpr_loader.sv
`default_nettype none
// Bench for gx4000_cpr_loader: scripted CPR images, write scoreboard and ack responder.
module tb_gx4000_cpr_loader;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic        ioctl_wait;
    logic [22:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_wr;
    logic        mem_ack = 1'b0;
    logic        load_done;
    logic        load_error;
    logic [31:0] bank_mask;

    gx4000_cpr_loader dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr), .mem_ack(mem_ack),
        .load_done(load_done), .load_error(load_error), .bank_mask(bank_mask)
    );

    always #5 clk_sys = ~clk_sys;

    int errors = 0;
    int checks = 0;
    logic [30:0] sb[$];
    int exp_wr = 0;
    int wr_count = 0;
    int ack_dly = 0;
    int age = 0;
    int last_len = 0;
    logic [22:0] cap_addr;
    logic [7:0]  cap_data;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // SDRAM arbiter model: checks each write against the scoreboard and acks after ack_dly cycles
    always @(negedge clk_sys) begin
        logic [30:0] e;
        mem_ack = 1'b0;
        if (mem_wr) begin
            if (age == 0) begin
                wr_count++;
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    if (mem_addr !== e[30:8] || mem_data !== e[7:0]) begin
                        check("wr_addr", {9'd0, mem_addr}, {9'd0, e[30:8]});
                        check("wr_data", {24'd0, mem_data}, {24'd0, e[7:0]});
                    end else begin
                        checks++;
                    end
                end
                cap_addr = mem_addr;
                cap_data = mem_data;
            end else if (mem_addr !== cap_addr || mem_data !== cap_data) begin
                check("wr_stable", {1'b0, mem_addr, mem_data}, {1'b0, cap_addr, cap_data});
            end
            if (!ioctl_wait) check("wait_with_wr", {31'd0, ioctl_wait}, 32'd1);
            if (age == ack_dly) mem_ack = 1'b1;
            age++;
        end else begin
            if (age != 0) last_len = age;
            age = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (ioctl_wait && n < 50000) begin
            @(negedge clk_sys);
            n++;
        end
        if (ioctl_wait) check("wait_timeout", {31'd0, ioctl_wait}, 32'd0);
        ioctl_wr   = 1'b1;
        ioctl_dout = b;
        @(negedge clk_sys);
        ioctl_wr   = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    endtask

    task automatic send_le32(input logic [31:0] v);
        for (int i = 0; i < 4; i++) send_byte(v[8*i +: 8]);
    endtask

    task automatic send_data(input logic [22:0] addr, input logic [7:0] b);
        sb.push_back({addr, b});
        exp_wr++;
        send_byte(b);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((mem_wr || ioctl_wait) && n < 50000) begin
            @(negedge clk_sys);
            n++;
        end
        if (mem_wr) check("idle_timeout", {31'd0, mem_wr}, 32'd0);
        tick(1);
    endtask

    task automatic start_dl();
        ioctl_download = 1'b1;
        tick(2);
        send_word("RIFF");
        send_le32(32'h0000_1234);
        send_word("AMS!");
    endtask

    task automatic stop_dl();
        wait_idle();
        ioctl_download = 1'b0;
        tick(3);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_wait"}, {31'd0, ioctl_wait}, 32'd0);
        check({tag, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
        check({tag, "_addr"}, {9'd0, mem_addr}, 32'd0);
        check({tag, "_data"}, {24'd0, mem_data}, 32'd0);
        check({tag, "_done"}, {31'd0, load_done}, 32'd0);
        check({tag, "_error"}, {31'd0, load_error}, 32'd0);
        check({tag, "_mask"}, bank_mask, 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check_reset_vals("reset");
        reset = 1'b0;
        tick(2);

`ifdef CPR_FILL_EN
        start_dl();
        send_word("cb02");
        send_le32(32'd1);
        send_data(23'h008000, 8'h3C);
        for (int i = 1; i < 16384; i++) begin
            sb.push_back({23'h008000 + 23'(i), 8'hFF});
            exp_wr++;
        end
        send_byte(8'hEE);
        stop_dl();
        check("fill_done", {31'd0, load_done}, 32'd1);
        check("fill_mask", bank_mask, 32'h0000_0004);
        check("fill_count", 32'(wr_count), 32'(exp_wr));
        check("fill_sb_empty", 32'(sb.size()), 32'd0);
`else
        // Multi-chunk image: cb banks, delayed ack, skipped/padded chunks, duplicates
        start_dl();
        send_word("cb00");
        send_le32(32'd4);
        send_data(23'h000000, 8'h11);
        send_data(23'h000001, 8'h22);
        send_data(23'h000002, 8'h33);
        send_data(23'h000003, 8'h44);
        send_word("cb05");
        send_le32(32'd2);
        ack_dly = 5;
        send_data(23'h014000, 8'hAA);
        wait_idle();
        check("ack_len", 32'(last_len), 32'd6);
        send_data(23'h014001, 8'hBB);
        wait_idle();
        ack_dly = 0;
        check("mask_b5", {31'd0, bank_mask[5]}, 32'd1);
        send_word("fmt ");
        send_le32(32'd3);
        send_word(32'h0102_03EE);
        send_word("cb01");
        send_le32(32'd1);
        send_data(23'h004000, 8'h5C);
        send_byte(8'hEE);
        send_word("cb32");
        send_le32(32'd2);
        send_byte(8'h01);
        send_byte(8'h02);
        send_word("cb07");
        send_le32(32'd0);
        send_word("cb31");
        send_le32(32'd1);
        send_data(23'h07C000, 8'h77);
        send_byte(8'hEE);
        send_word("cb00");
        send_le32(32'd1);
        send_data(23'h000000, 8'h99);
        send_byte(8'hEE);
        wait_idle();
        check("busy_before_drop", {31'd0, load_done}, 32'd0);
        stop_dl();
        check("a_done", {31'd0, load_done}, 32'd1);
        check("a_error", {31'd0, load_error}, 32'd0);
        check("a_mask", bank_mask, 32'h8000_0023);
        check("a_count", 32'(wr_count), 32'(exp_wr));
        check("a_sb_empty", 32'(sb.size()), 32'd0);

        // Bad magic: everything after is ignored at full rate
        ioctl_download = 1'b1;
        tick(2);
        check("restart_clears_done", {31'd0, load_done}, 32'd0);
        send_word("RIFX");
        send_le32(32'd20);
        send_word("AMS!");
        send_word("cb00");
        send_le32(32'd2);
        send_byte(8'h55);
        send_byte(8'h66);
        tick(2);
        check("bad_error", {31'd0, load_error}, 32'd1);
        check("bad_count", 32'(wr_count), 32'(exp_wr));
        check("bad_mask", bank_mask, 32'd0);
        stop_dl();
        check("bad_done", {31'd0, load_done}, 32'd0);
        check("bad_error_hold", {31'd0, load_error}, 32'd1);

        // Truncated chunk data
        start_dl();
        check("restart_clears_err", {31'd0, load_error}, 32'd0);
        send_word("cb02");
        send_le32(32'd4);
        send_data(23'h008000, 8'h12);
        send_data(23'h008001, 8'h34);
        stop_dl();
        check("trunc_error", {31'd0, load_error}, 32'd1);
        check("trunc_done", {31'd0, load_done}, 32'd0);
        check("trunc_count", 32'(wr_count), 32'(exp_wr));

        // Reset while a write is held
        start_dl();
        send_word("cb03");
        send_le32(32'd4);
        ack_dly = 20;
        send_data(23'h00C000, 8'h51);
        tick(2);
        check("pre_reset_wr", {31'd0, mem_wr}, 32'd1);
        reset = 1'b1;
        ioctl_download = 1'b0;
        tick(1);
        check_reset_vals("midreset");
        reset = 1'b0;
        ack_dly = 0;
        tick(3);
        check("post_reset_wr", {31'd0, mem_wr}, 32'd0);
        check("final_sb_empty", 32'(sb.size()), 32'd0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
